// File: rtl/op_read_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// op_read_hazard_ctrl
//   Producer-side control for the op-read -> execute pipeline latch. Each
//   cycle it decides whether the decoded instruction is loaded into the latch
//   or a bubble is inserted. A 3-deep destination scoreboard (EX, MEM, WB)
//   tracks issued instructions for RAW hazard detection. Forwarding selects
//   are registered so they line up with the latch outputs.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   dec_valid_i         decode holds a valid instruction
//   rs1_i/rs2_i         source register indices
//   use_rs1_i/use_rs2_i instruction reads rs1 / rs2
//   rd_i, rd_wr_i       destination index and write enable
//   is_load_i           instruction is a load
//   flush_i             decoded instruction is wrong-path
//   latch_ena_o         op-read latch enable (combinational)
//   stall_out_o         hold fetch/decode (combinational)
//   fwd_sel_rs1_o/rs2_o registered forwarding select: 0 RF, 1 MEM, 2 WB
//   stall_cnt_o         saturating count of hazard stall cycles
// ----------------------------------------------------------------------------
module op_read_hazard_ctrl #(
    parameter bit          FWD_EN = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    input  logic             use_rs1_i,
    input  logic             use_rs2_i,
    input  logic [4:0]       rd_i,
    input  logic             rd_wr_i,
    input  logic             is_load_i,
    input  logic             flush_i,
    output logic             latch_ena_o,
    output logic             stall_out_o,
    output logic [1:0]       fwd_sel_rs1_o,
    output logic [1:0]       fwd_sel_rs2_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned FWD_W = 2;

    localparam logic [FWD_W-1:0] FWD_RF  = FWD_W'(0);
    localparam logic [FWD_W-1:0] FWD_MEM = FWD_W'(1);
    localparam logic [FWD_W-1:0] FWD_WB  = FWD_W'(2);

    // Scoreboard entry; the load flag is only needed in EX, kept separately.
    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
    } sb_entry_t;

    sb_entry_t sb_ex_q,  sb_ex_d;
    sb_entry_t sb_mem_q;
    sb_entry_t sb_wb_q;
    logic      ex_ld_q,  ex_ld_d;

    logic [FWD_W-1:0] fwd_sel_rs1_q, fwd_sel_rs1_d;
    logic [FWD_W-1:0] fwd_sel_rs2_q, fwd_sel_rs2_d;
    logic [CNT_W-1:0] stall_cnt_q,   stall_cnt_d;

    logic m_ex1_c, m_ex2_c, m_mem1_c, m_mem2_c, m_wb1_c, m_wb2_c;
    logic hazard_c;
    logic latch_ena_c;
    logic stall_c;

    function automatic logic src_match(input sb_entry_t e, input logic use_r,
                                       input logic [REG_W-1:0] r);
        return use_r && (r != '0) && e.v && (e.rd == r);
    endfunction

    // Hazard detection and issue decision
    always_comb begin
        m_ex1_c  = src_match(sb_ex_q,  use_rs1_i, rs1_i);
        m_ex2_c  = src_match(sb_ex_q,  use_rs2_i, rs2_i);
        m_mem1_c = src_match(sb_mem_q, use_rs1_i, rs1_i);
        m_mem2_c = src_match(sb_mem_q, use_rs2_i, rs2_i);
        m_wb1_c  = src_match(sb_wb_q,  use_rs1_i, rs1_i);
        m_wb2_c  = src_match(sb_wb_q,  use_rs2_i, rs2_i);

        if (FWD_EN) begin
            // Only a load in EX cannot be forwarded in time.
            hazard_c = ex_ld_q && (m_ex1_c || m_ex2_c);
        end else begin
            hazard_c = m_ex1_c || m_ex2_c || m_mem1_c || m_mem2_c || m_wb1_c || m_wb2_c;
        end

        // flush dominates the hazard: no stall, no issue.
        stall_c     = dec_valid_i && hazard_c && !flush_i;
        latch_ena_c = dec_valid_i && !hazard_c && !flush_i;
    end

    // Next-state for scoreboard, forwarding selects and stall counter
    always_comb begin
        sb_ex_d       = '0;
        ex_ld_d       = 1'b0;
        fwd_sel_rs1_d = FWD_RF;
        fwd_sel_rs2_d = FWD_RF;
        stall_cnt_d   = stall_cnt_q;

        if (latch_ena_c) begin
            sb_ex_d.v  = rd_wr_i && (rd_i != '0);
            sb_ex_d.rd = rd_i;
            ex_ld_d    = is_load_i;
        end

        // Youngest producer (EX) takes priority over MEM.
        if (latch_ena_c && FWD_EN) begin
            if (m_ex1_c)       fwd_sel_rs1_d = FWD_MEM;
            else if (m_mem1_c) fwd_sel_rs1_d = FWD_WB;
            if (m_ex2_c)       fwd_sel_rs2_d = FWD_MEM;
            else if (m_mem2_c) fwd_sel_rs2_d = FWD_WB;
        end

        if (stall_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers; the scoreboard advances every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_ex_q       <= '0;
            sb_mem_q      <= '0;
            sb_wb_q       <= '0;
            ex_ld_q       <= 1'b0;
            fwd_sel_rs1_q <= FWD_RF;
            fwd_sel_rs2_q <= FWD_RF;
            stall_cnt_q   <= '0;
        end else begin
            sb_wb_q       <= sb_mem_q;
            sb_mem_q      <= sb_ex_q;
            sb_ex_q       <= sb_ex_d;
            ex_ld_q       <= ex_ld_d;
            fwd_sel_rs1_q <= fwd_sel_rs1_d;
            fwd_sel_rs2_q <= fwd_sel_rs2_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign latch_ena_o   = latch_ena_c;
    assign stall_out_o   = stall_c;
    assign fwd_sel_rs1_o = fwd_sel_rs1_q;
    assign fwd_sel_rs2_o = fwd_sel_rs2_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_op_read_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_op_read_hazard_ctrl
//   Three instances share one stimulus stream: FWD_EN=1/CNT_W=16,
//   FWD_EN=0/CNT_W=16 and FWD_EN=1/CNT_W=4. The reference model remembers,
//   per architectural register, the cycle in which its youngest writer issued;
//   the producer's pipeline position follows from the age in cycles.
// ----------------------------------------------------------------------------
module tb_op_read_hazard_ctrl;

    localparam int NM    = 3;
    localparam int NEVER = -1000000;

    logic       clk;
    logic       rst_n;
    logic       dec_valid;
    logic [4:0] rs1, rs2, rd;
    logic       use_rs1, use_rs2, rd_wr, is_load, flush;

    logic        latch_ena [NM];
    logic        stall_out [NM];
    logic [1:0]  fwd1      [NM];
    logic [1:0]  fwd2      [NM];
    logic [15:0] cnt0, cnt1;
    logic [3:0]  cnt2;

    op_read_hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(16)) u_fwd (
        .clk(clk), .rst_n(rst_n), .dec_valid_i(dec_valid),
        .rs1_i(rs1), .rs2_i(rs2), .use_rs1_i(use_rs1), .use_rs2_i(use_rs2),
        .rd_i(rd), .rd_wr_i(rd_wr), .is_load_i(is_load), .flush_i(flush),
        .latch_ena_o(latch_ena[0]), .stall_out_o(stall_out[0]),
        .fwd_sel_rs1_o(fwd1[0]), .fwd_sel_rs2_o(fwd2[0]), .stall_cnt_o(cnt0));

    op_read_hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(16)) u_nofwd (
        .clk(clk), .rst_n(rst_n), .dec_valid_i(dec_valid),
        .rs1_i(rs1), .rs2_i(rs2), .use_rs1_i(use_rs1), .use_rs2_i(use_rs2),
        .rd_i(rd), .rd_wr_i(rd_wr), .is_load_i(is_load), .flush_i(flush),
        .latch_ena_o(latch_ena[1]), .stall_out_o(stall_out[1]),
        .fwd_sel_rs1_o(fwd1[1]), .fwd_sel_rs2_o(fwd2[1]), .stall_cnt_o(cnt1));

    op_read_hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .dec_valid_i(dec_valid),
        .rs1_i(rs1), .rs2_i(rs2), .use_rs1_i(use_rs1), .use_rs2_i(use_rs2),
        .rd_i(rd), .rd_wr_i(rd_wr), .is_load_i(is_load), .flush_i(flush),
        .latch_ena_o(latch_ena[2]), .stall_out_o(stall_out[2]),
        .fwd_sel_rs1_o(fwd1[2]), .fwd_sel_rs2_o(fwd2[2]), .stall_cnt_o(cnt2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int cyc;
    int last_t  [NM][32];
    bit last_ld [NM][32];
    int mcnt    [NM];
    int exp_f1  [NM];
    int exp_f2  [NM];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp_v);
        end
    endtask

    function automatic bit cfg_fwd(input int m);
        return m != 1;
    endfunction

    function automatic int cfg_max(input int m);
        return (m == 2) ? 15 : 65535;
    endfunction

    function automatic int age(input int m, input logic [4:0] r);
        return cyc - last_t[m][r];
    endfunction

    // A source is blocked if its youngest writer is still in flight and cannot supply it.
    function automatic bit src_blocked(input int m, input bit u, input logic [4:0] r);
        int a;
        if (!u || r == 5'd0) return 1'b0;
        a = age(m, r);
        if (cfg_fwd(m)) return (a == 1) && last_ld[m][r];
        return (a >= 1) && (a <= 3);
    endfunction

    // EX at issue time means MEM next cycle (1); MEM means WB next cycle (2).
    function automatic int src_fwd(input int m, input bit u, input logic [4:0] r);
        int a;
        if (!u || r == 5'd0) return 0;
        a = age(m, r);
        if (a == 1) return 1;
        if (a == 2) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < NM; m++) begin
            for (int r = 0; r < 32; r++) begin
                last_t[m][r]  = NEVER;
                last_ld[m][r] = 1'b0;
            end
            mcnt[m]   = 0;
            exp_f1[m] = 0;
            exp_f2[m] = 0;
        end
    endtask

    function automatic logic [31:0] cnt_of(input int m);
        case (m)
            0:       return 32'(cnt0);
            1:       return 32'(cnt1);
            default: return 32'(cnt2);
        endcase
    endfunction

    // Drive one decoded instruction at negedge, check combinational outputs, advance model.
    task automatic drive(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                         input int d, input bit wr, input bit ld, input bit fl);
        bit h, es, el;
        @(negedge clk);
        dec_valid = v;   rs1 = 5'(r1); use_rs1 = u1; rs2 = 5'(r2); use_rs2 = u2;
        rd = 5'(d);      rd_wr = wr;   is_load = ld; flush = fl;
        #1;
        for (int m = 0; m < NM; m++) begin
            h  = src_blocked(m, u1, rs1) || src_blocked(m, u2, rs2);
            es = v && h && !fl;
            el = v && !h && !fl;
            check($sformatf("stall_out[%0d]", m), 32'(stall_out[m]), 32'(es));
            check($sformatf("latch_ena[%0d]", m), 32'(latch_ena[m]), 32'(el));
            exp_f1[m] = (el && cfg_fwd(m)) ? src_fwd(m, u1, rs1) : 0;
            exp_f2[m] = (el && cfg_fwd(m)) ? src_fwd(m, u2, rs2) : 0;
            if (es && mcnt[m] < cfg_max(m)) mcnt[m]++;
            if (el && wr && rd != 5'd0) begin
                last_t[m][rd]  = cyc;
                last_ld[m][rd] = ld;
            end
        end
    endtask

    // Clock edge, then check registered outputs.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int m = 0; m < NM; m++) begin
            check($sformatf("fwd_sel_rs1[%0d]", m), 32'(fwd1[m]), 32'(exp_f1[m]));
            check($sformatf("fwd_sel_rs2[%0d]", m), 32'(fwd2[m]), 32'(exp_f2[m]));
            check($sformatf("stall_cnt[%0d]", m), cnt_of(m), 32'(mcnt[m]));
        end
    endtask

    task automatic step(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                        input int d, input bit wr, input bit ld, input bit fl);
        drive(v, r1, u1, r2, u2, d, wr, ld, fl);
        tick();
    endtask

    // Async reset asserted away from the clock edge, with current inputs held.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int m = 0; m < NM; m++) begin
            check($sformatf("rst stall_out[%0d]", m), 32'(stall_out[m]), 32'd0);
            check($sformatf("rst latch_ena[%0d]", m), 32'(latch_ena[m]),
                  32'(dec_valid && !flush));
            check($sformatf("rst fwd1[%0d]", m), 32'(fwd1[m]), 32'd0);
            check($sformatf("rst fwd2[%0d]", m), 32'(fwd2[m]), 32'd0);
            check($sformatf("rst cnt[%0d]", m), cnt_of(m), 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Shorthands: v, rs1, use1, rs2, use2, rd, wr, load, flush
    task automatic alu(input int d, input int a, input int b);
        step(1, a, 1, b, 1, d, 1, 0, 0);
    endtask
    task automatic lw(input int d, input int a);
        step(1, a, 1, 0, 0, d, 1, 1, 0);
    endtask
    task automatic bubble();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        cyc = 0;
        rst_n = 1'b1;
        dec_valid = 0; rs1 = 0; rs2 = 0; rd = 0;
        use_rs1 = 0; use_rs2 = 0; rd_wr = 0; is_load = 0; flush = 0;
        #2;
        do_reset();
        for (int i = 0; i < 2; i++) bubble();

        // 1. Reset in the middle of a load-use stall
        lw(5, 1);
        drive(1, 5, 1, 0, 0, 6, 1, 0, 0);
        check("mid-stall stall_out[0]", 32'(stall_out[0]), 32'd1);
        do_reset();
        bubble();

        // 2. Back-to-back ALU dependency, forwarded from MEM
        alu(3, 1, 2);
        alu(4, 3, 0);
        check("ex->mem fwd1[0]", 32'(fwd1[0]), 32'd1);
        for (int i = 0; i < 4; i++) bubble();

        // 3. Load-use: one bubble, then WB forward on both sources
        do_reset();
        lw(7, 1);
        step(1, 7, 1, 7, 1, 8, 1, 0, 0);
        step(1, 7, 1, 7, 1, 8, 1, 0, 0);
        check("load-use fwd1[0]", 32'(fwd1[0]), 32'd2);
        check("load-use fwd2[0]", 32'(fwd2[0]), 32'd2);
        check("load-use cnt[0]", 32'(cnt0), 32'd1);
        for (int i = 0; i < 4; i++) bubble();

        // 4. No forwarding: consumer waits for producer to leave WB
        do_reset();
        alu(9, 1, 2);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 9, 1, 10, 1, 0, 0);
        check("nofwd cnt[1]", 32'(cnt1), 32'd3);
        check("nofwd fwd2[1]", 32'(fwd2[1]), 32'd0);
        for (int i = 0; i < 4; i++) bubble();

        // 5. x0 never forms a dependency; rd_wr=0 producer never matches
        lw(0, 1);
        step(1, 0, 1, 0, 1, 11, 1, 0, 0);
        step(1, 2, 1, 0, 0, 12, 0, 1, 0);
        step(1, 12, 1, 12, 1, 13, 1, 0, 0);
        for (int i = 0; i < 4; i++) bubble();

        // 6. flush during load-use stall, then counter saturation
        lw(14, 1);
        step(1, 14, 1, 0, 0, 15, 1, 0, 1);
        for (int i = 0; i < 20; i++) begin
            lw(7, 1);
            step(1, 7, 1, 7, 1, 8, 1, 0, 0);
            step(1, 7, 1, 7, 1, 8, 1, 0, 0);
        end
        check("sat cnt[2]", 32'(cnt2), 32'd15);

        // Randomized traffic on a small register window to provoke hazards
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                drive(1, $urandom_range(0, 7), 1, $urandom_range(0, 7), 1,
                      $urandom_range(0, 7), 1, 1, 0);
                do_reset();
            end else begin
                step($urandom_range(0, 7) != 0,
                     $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                     $urandom_range(0, 7), $urandom_range(0, 1),
                     $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                     $urandom_range(0, 2) == 0,
                     $urandom_range(0, 9) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
